// File: rtl/reg_dump_streamer.sv
// Register dump streamer: walks REG_FIRST..REG_LAST on the CPU debug port and emits each word MSB-first on a valid/ready byte stream.
// Optional REG_DUMP_HEADER_EN prefixes the stream with 0xA5 and the PC captured at trigger time.
module reg_dump_streamer #(
  parameter int unsigned REG_FIRST = 0,
  parameter int unsigned REG_LAST  = 31,
  parameter logic [31:0] STOP_PC   = 32'h0000_0008,
  parameter bit          AUTO_STOP = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] pc_in,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FIRST_SEL = REG_FIRST[4:0];
  localparam logic [4:0] LAST_SEL  = REG_LAST[4:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_LOAD,
    S_SEND,
    S_FIN
`ifdef REG_DUMP_HEADER_EN
    , S_HDR
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  sel_q, sel_d;
  logic [31:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic        busy_q, busy_d;
`ifdef REG_DUMP_HEADER_EN
  logic [31:0] pc_q, pc_d;
  logic [2:0]  hcnt_q, hcnt_d;
`endif

  logic auto_hit;
  logic trigger;
  logic hs;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      sel_q   <= 5'd0;
      shift_q <= 32'd0;
      cnt_q   <= 2'd0;
      armed_q <= 1'b1;
      busy_q  <= 1'b0;
`ifdef REG_DUMP_HEADER_EN
      pc_q    <= 32'd0;
      hcnt_q  <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      busy_q  <= busy_d;
`ifdef REG_DUMP_HEADER_EN
      pc_q    <= pc_d;
      hcnt_q  <= hcnt_d;
`endif
    end
  end

  // Auto trigger fires once per reset so a CPU spinning at STOP_PC yields one dump.
  assign auto_hit = AUTO_STOP && armed_q && (pc_in == STOP_PC);
  assign trigger  = start || auto_hit;
  assign hs       = tx_valid && tx_ready;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    armed_d  = armed_q;
    busy_d   = busy_q;
`ifdef REG_DUMP_HEADER_EN
    pc_d     = pc_q;
    hcnt_d   = hcnt_q;
`endif
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          busy_d = 1'b1;
          sel_d  = FIRST_SEL;
          if (auto_hit) armed_d = 1'b0;
`ifdef REG_DUMP_HEADER_EN
          pc_d    = pc_in;
          hcnt_d  = 3'd0;
          state_d = S_HDR;
`else
          state_d = S_SEL;
`endif
        end
      end
`ifdef REG_DUMP_HEADER_EN
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = (hcnt_q == 3'd0) ? 8'hA5 : pc_q[31:24];
        if (hs) begin
          hcnt_d = hcnt_q + 3'd1;
          if (hcnt_q != 3'd0) pc_d = {pc_q[23:0], 8'h00};
          if (hcnt_q == 3'd4) state_d = S_SEL;
        end
      end
`endif
      S_SEL: state_d = S_LOAD;
      S_LOAD: begin
        shift_d = reg_data;
        cnt_d   = 2'd0;
        state_d = S_SEND;
      end
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = shift_q[31:24];
        if (hs) begin
          shift_d = {shift_q[23:0], 8'h00};
          cnt_d   = cnt_q + 2'd1;
          // Termination by compare keeps REG_LAST = 31 from wrapping reg_sel.
          if (cnt_q == 2'd3) begin
            if (sel_q == LAST_SEL) begin
              state_d = S_FIN;
            end else begin
              sel_d   = sel_q + 5'd1;
              state_d = S_SEL;
            end
          end
        end
      end
      S_FIN: begin
        done    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign reg_sel = sel_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Directed bench for reg_dump_streamer: full dumps, stalled sink, ignored retrigger, async reset, auto stop.
`timescale 1ns/1ps
module tb_reg_dump_streamer;

`ifdef REG_DUMP_HEADER_EN
  localparam int HDR = 5;
`else
  localparam int HDR = 0;
`endif
  localparam int N = 32;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Full-range instance
  logic        start, tx_valid, tx_ready, busy, done;
  logic [31:0] pc_in, reg_data;
  logic [4:0]  reg_sel;
  logic [7:0]  tx_data;

  // Single-register instance (reg 5 only, start-triggered)
  logic        start1, valid1, ready1, busy1, done1;
  logic [31:0] pc1, data1;
  logic [4:0]  sel1;
  logic [7:0]  txd1;

  reg_dump_streamer u_full (
    .clk(clk), .rstn(rstn), .start(start), .pc_in(pc_in),
    .reg_sel(reg_sel), .reg_data(reg_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  reg_dump_streamer #(.REG_FIRST(5), .REG_LAST(5), .AUTO_STOP(1'b0)) u_one (
    .clk(clk), .rstn(rstn), .start(start1), .pc_in(pc1),
    .reg_sel(sel1), .reg_data(data1),
    .tx_valid(valid1), .tx_data(txd1), .tx_ready(ready1),
    .busy(busy1), .done(done1)
  );

  assign reg_data = 32'h1000_0000 + {27'd0, reg_sel};
  assign data1    = (sel1 == 5'd5) ? 32'hDEAD_BEEF : 32'h1000_0000 + {27'd0, sel1};

  // Byte/done/busy capture for the full instance
  logic [7:0] rxq[$];
  int done_cnt = 0;
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (tx_valid && tx_ready) rxq.push_back(tx_data);
    if (done) done_cnt = done_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  logic [7:0] expq[$];

  function automatic void build_exp(input int first, input int last, input logic [31:0] pc, input bit beef5);
    logic [31:0] w;
    expq = {};
    if (HDR != 0) begin
      expq.push_back(8'hA5);
      for (int b = 3; b >= 0; b--) expq.push_back(pc[8*b +: 8]);
    end
    for (int r = first; r <= last; r++) begin
      w = (beef5 && r == 5) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(r);
      for (int b = 3; b >= 0; b--) expq.push_back(w[8*b +: 8]);
    end
  endfunction

  task automatic cmp_stream(input string nm, input int base);
    chk({nm, "_len"}, 32'(rxq.size() - base), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++)
      if (base + i < rxq.size()) chk(nm, 32'(rxq[base + i]), 32'(expq[i]));
  endtask

  task automatic pulse_start(output int t0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        at = cyc;
        break;
      end
    end
    chk("done_seen", 32'(at >= 0), 32'd1);
  endtask

  task automatic wait_bytes(input int base, input int cnt);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (rxq.size() - base >= cnt) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bytes_reached", 32'(ok), 32'd1);
  endtask

  typedef struct {
    int         pos;
    logic [7:0] exp;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    vec_t vt[8];
    vec_t one_vt[4];
    logic [7:0] q1[$];
    int base, t0, at, d0, b0, n0;
    bit prev_stall, seen1;
    logic [7:0] prev_d;

    // Hand-computed bytes of the default dump (offsets exclude any header)
    vt[0] = '{0,   8'h10};
    vt[1] = '{1,   8'h00};
    vt[2] = '{3,   8'h00};
    vt[3] = '{7,   8'h01};
    vt[4] = '{83,  8'h14};
    vt[5] = '{124, 8'h10};
    vt[6] = '{126, 8'h00};
    vt[7] = '{127, 8'h1F};
    one_vt[0] = '{0, 8'hDE};
    one_vt[1] = '{1, 8'hAD};
    one_vt[2] = '{2, 8'hBE};
    one_vt[3] = '{3, 8'hEF};

    rstn = 1'b0; start = 1'b0; pc_in = 32'h0000_0100; tx_ready = 1'b1;
    start1 = 1'b0; pc1 = 32'h0000_0040; ready1 = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_reg_sel",  32'(reg_sel),  32'd0);
    chk("rst_valid1",   32'(valid1),   32'd0);
    @(posedge clk); #1 rstn = 1'b1;

    // Full dump with zero-wait sink
    base = rxq.size(); d0 = done_cnt;
    pulse_start(t0);
    wait_done(400, at);
    chk("latency_dump1", 32'(at - t0 + 1), 32'(6 * N + 1 + HDR));
    @(negedge clk); #1;
    chk("busy_after_dump1", 32'(busy), 32'd0);
    chk("done_single_dump1", 32'(done_cnt - d0), 32'd1);
    chk("reg_sel_hold", 32'(reg_sel), 32'd31);
    build_exp(0, 31, 32'h0000_0100, 1'b0);
    cmp_stream("dump1", base);
    for (int i = 0; i < 8; i++)
      if (base + HDR + vt[i].pos < rxq.size())
        chk("dump1_vec", 32'(rxq[base + HDR + vt[i].pos]), 32'(vt[i].exp));

    // Retrigger at byte 10 is ignored
    base = rxq.size(); d0 = done_cnt;
    pulse_start(t0);
    wait_bytes(base, 10);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(400, at);
    chk("latency_retrig", 32'(at - t0 + 1), 32'(6 * N + 1 + HDR));
    repeat (20) @(negedge clk);
    #1;
    chk("busy_after_retrig", 32'(busy), 32'd0);
    chk("done_single_retrig", 32'(done_cnt - d0), 32'd1);
    cmp_stream("retrig", base);

    // Asynchronous reset in SEND at byte 50
    base = rxq.size();
    pulse_start(t0);
    wait_bytes(base, 50 + HDR);
    @(posedge clk); #1;
    chk("pre_rst_valid", 32'(tx_valid), 32'd1);
    rstn = 1'b0;
    #1;
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("midrst_busy",     32'(busy),     32'd0);
    chk("midrst_reg_sel",  32'(reg_sel),  32'd0);
    chk("midrst_done",     32'(done),     32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    base = rxq.size(); d0 = done_cnt;
    pulse_start(t0);
    wait_done(400, at);
    chk("latency_after_rst", 32'(at - t0 + 1), 32'(6 * N + 1 + HDR));
    @(negedge clk); #1;
    chk("done_single_after_rst", 32'(done_cnt - d0), 32'd1);
    cmp_stream("after_rst", base);

    // Single register, sink ready toggling every cycle
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    prev_stall = 1'b0; prev_d = 8'h00; seen1 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1 ready1 = ~ready1;
      @(negedge clk);
      if (prev_stall) begin
        chk("stall_valid", 32'(valid1), 32'd1);
        chk("stall_data",  32'(txd1),   32'(prev_d));
      end
      if (valid1 && ready1) q1.push_back(txd1);
      if (done1) begin
        seen1 = 1'b1;
        chk("one_bytes_at_done", 32'(q1.size()), 32'(4 + HDR));
        break;
      end
      prev_stall = valid1 && !ready1;
      prev_d = txd1;
    end
    chk("one_done_seen", 32'(seen1), 32'd1);
    @(negedge clk);
    chk("one_busy_after", 32'(busy1), 32'd0);
    chk("one_done_pulse", 32'(done1), 32'd0);
    build_exp(5, 5, 32'h0000_0040, 1'b1);
    for (int i = 0; i < expq.size(); i++)
      if (i < q1.size()) chk("one_stream", 32'(q1[i]), 32'(expq[i]));
    for (int i = 0; i < 4; i++)
      if (HDR + one_vt[i].pos < q1.size())
        chk("one_vec", 32'(q1[HDR + one_vt[i].pos]), 32'(one_vt[i].exp));

    // Auto stop at PC 8, then the PC parks there
    base = rxq.size(); d0 = done_cnt;
    @(posedge clk); #1 pc_in = 32'h0000_0000;
    @(negedge clk); chk("auto_pc0_idle", 32'(busy), 32'd0);
    @(posedge clk); #1 pc_in = 32'h0000_0004;
    @(negedge clk); chk("auto_pc4_idle", 32'(busy), 32'd0);
    @(posedge clk); #1 pc_in = 32'h0000_0008;
    @(negedge clk); chk("auto_pc8_before_edge", 32'(busy), 32'd0);
    @(posedge clk); #1;
    t0 = cyc;
    chk("auto_busy_next_cycle", 32'(busy), 32'd1);
    chk("auto_reg_sel_first", 32'(reg_sel), 32'd0);
    wait_done(400, at);
    chk("latency_auto", 32'(at - t0 + 1), 32'(6 * N + 1 + HDR));
    @(negedge clk); #1;
    b0 = busy_cnt; n0 = rxq.size();
    repeat (300) @(posedge clk);
    @(negedge clk); #1;
    chk("auto_no_rebusy", 32'(busy_cnt - b0), 32'd0);
    chk("auto_no_more_bytes", 32'(rxq.size() - n0), 32'd0);
    chk("auto_single_done", 32'(done_cnt - d0), 32'd1);
    build_exp(0, 31, 32'h0000_0008, 1'b0);
    cmp_stream("auto", base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
